// File: rtl/pll_lock_sequencer_if.sv
// PLL sequencer signal bundle: lock/relock inputs and reset/status outputs.
// master = sequencer side, slave = PLL/consumer side.
// Optional LOCK_LOSS_COUNT_EN adds the 8-bit loss_count status field.
interface pll_lock_sequencer_if #(
   parameter int RW = 2
);
   logic          pll_lock;
   logic          relock_req;
   logic          pll_rst;
   logic          sys_rst_n;
   logic          locked;
   logic          fault;
   logic [RW-1:0] retry_count;
`ifdef LOCK_LOSS_COUNT_EN
   logic [7:0]    loss_count;
`endif

   modport master (
      input  pll_lock,
      input  relock_req,
      output pll_rst,
      output sys_rst_n,
      output locked,
      output fault,
      output retry_count
`ifdef LOCK_LOSS_COUNT_EN
      , output loss_count
`endif
   );

   modport slave (
      output pll_lock,
      output relock_req,
      input  pll_rst,
      input  sys_rst_n,
      input  locked,
      input  fault,
      input  retry_count
`ifdef LOCK_LOSS_COUNT_EN
      , input loss_count
`endif
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: reset pulse, lock wait with timeout/retry, stability qualification, loss filter.
// Latency: pll_lock sees a 2-flop synchronizer; all outputs are registered state decodes.
// No backpressure; relock_req is a single-cycle request. Optional: LOCK_LOSS_COUNT_EN adds loss_count.
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 64,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int LOSS_FILTER   = 4
) (
   input  logic                  init_clk,
   input  logic                  reset_n,
   pll_lock_sequencer_if.master  bus
);

   localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B   = (STABLE_CYCLES > LOSS_FILTER) ? STABLE_CYCLES : LOSS_FILTER;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_FILTER - 1);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          lock_meta_q, lock_s_q;
   logic          pll_rst_q, pll_rst_d;
   logic          sys_rst_n_q, sys_rst_n_d;
   logic          locked_q, locked_d;
   logic          fault_q, fault_d;

   // Two-flop synchronizer for the asynchronous PLL lock indication
   always_ff @(posedge init_clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= bus.pll_lock;
         lock_s_q    <= lock_meta_q;
      end
   end

   // State, shared counter, retry count and registered outputs
   always_ff @(posedge init_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_RESET;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         locked_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         locked_q    <= locked_d;
         fault_q     <= fault_d;
      end
   end

   // Next state, retry bookkeeping and counter; relock overrides everything except in RESET
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      unique case (state_q)
         S_RESET: begin
            if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = S_STABLE;
            end else if (cnt_q == TO_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_RESET;
               end else begin
                  state_d = S_FAULT;
               end
            end
         end
         S_STABLE: begin
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               retry_d = '0;
            end
         end
         S_RUN: begin
            if (!lock_s_q && (cnt_q == LOSS_LAST)) state_d = S_RESET;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_RESET;
         end
      endcase

      if (bus.relock_req && (state_q != S_RESET)) begin
         state_d = S_RESET;
         retry_d = '0;
      end

      // In RUN the counter tracks consecutive synced-low cycles; FAULT parks it at zero
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == S_RUN) begin
         cnt_d = lock_s_q ? '0 : cnt_q + 1'b1;
      end else if (state_q == S_FAULT) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Output decode from the next state so outputs change on the transition edge
   always_comb begin
      pll_rst_d   = (state_d == S_RESET) || (state_d == S_FAULT);
      sys_rst_n_d = (state_d == S_RUN);
      locked_d    = (state_d == S_RUN);
      fault_d     = (state_d == S_FAULT);
   end

`ifdef LOCK_LOSS_COUNT_EN
   logic       loss_event;
   logic [7:0] loss_cnt_q;

   // A RUN->RESET exit is a lock loss unless relock_req forced it
   always_comb begin
      loss_event = (state_q == S_RUN) && (state_d == S_RESET) && !bus.relock_req;
   end

   // Saturating lock-loss event counter, cleared only by reset_n
   always_ff @(posedge init_clk or negedge reset_n) begin
      if (!reset_n) begin
         loss_cnt_q <= 8'd0;
      end else if (loss_event && (loss_cnt_q != 8'hFF)) begin
         loss_cnt_q <= loss_cnt_q + 8'd1;
      end
   end

   assign bus.loss_count = loss_cnt_q;
`endif

   assign bus.pll_rst     = pll_rst_q;
   assign bus.sys_rst_n   = sys_rst_n_q;
   assign bus.locked      = locked_q;
   assign bus.fault       = fault_q;
   assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: table of held-input segments plus hand sequences.
// Observed vector per check: {pll_rst, sys_rst_n, locked, fault, retry_count[1:0]}.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_pll_lock_sequencer;

   logic init_clk = 1'b0;
   logic reset_n  = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   pll_lock_sequencer_if #(.RW(2)) bus ();

   pll_lock_sequencer #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .MAX_RETRIES  (2),
      .LOSS_FILTER  (3)
   ) dut (
      .init_clk(init_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 init_clk = ~init_clk;

   typedef struct {
      int         n;
      logic       lock;
      logic       relock;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl[17];

   function automatic logic [5:0] obs();
      return {bus.pll_rst, bus.sys_rst_n, bus.locked, bus.fault, bus.retry_count};
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge init_clk);
      #1;
   endtask

   // Asynchronous reset mid-cycle, checked before any clock edge, then released after one edge
   task automatic do_reset(input string name);
      #3;
      reset_n = 1'b0;
      #1;
      check(name, {2'b00, obs()}, 8'b0010_0000);
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // {cycles, pll_lock, relock_req, expected obs during those cycles}
      tbl[0]  = '{3,  1'b0, 1'b0, 6'b100000}; // RESET pulse
      tbl[1]  = '{7,  1'b0, 1'b0, 6'b000000}; // WAIT_LOCK, lock rises 6 cycles after pll_rst falls
      tbl[2]  = '{10, 1'b1, 1'b0, 6'b000000}; // sync delay + STABLE
      tbl[3]  = '{3,  1'b1, 1'b0, 6'b011000}; // RUN
      tbl[4]  = '{2,  1'b0, 1'b0, 6'b011000}; // 2-cycle glitch
      tbl[5]  = '{6,  1'b1, 1'b0, 6'b011000}; // glitch ignored
      tbl[6]  = '{4,  1'b0, 1'b0, 6'b011000}; // 3-cycle loss still in sync pipe
      tbl[7]  = '{4,  1'b0, 1'b0, 6'b100000}; // loss -> RESET for 4 cycles
      tbl[8]  = '{20, 1'b0, 1'b0, 6'b000000}; // first wait
      tbl[9]  = '{4,  1'b0, 1'b0, 6'b100001}; // retry 1
      tbl[10] = '{20, 1'b0, 1'b0, 6'b000001};
      tbl[11] = '{4,  1'b0, 1'b0, 6'b100010}; // retry 2
      tbl[12] = '{20, 1'b0, 1'b0, 6'b000010};
      tbl[13] = '{10, 1'b0, 1'b0, 6'b100110}; // FAULT held
      tbl[14] = '{1,  1'b0, 1'b1, 6'b100000}; // relock out of FAULT
      tbl[15] = '{3,  1'b0, 1'b0, 6'b100000}; // fresh 4-cycle RESET
      tbl[16] = '{2,  1'b0, 1'b0, 6'b000000}; // WAIT_LOCK again

      bus.pll_lock   = 1'b0;
      bus.relock_req = 1'b0;

      // Reset state while reset_n is held
      tick();
      tick();
      check("reset_hold", {2'b00, obs()}, 8'b0010_0000);
`ifdef LOCK_LOSS_COUNT_EN
      check("reset_loss_count", bus.loss_count, 8'd0);
`endif
      reset_n = 1'b1;

      // Nominal bring-up, RUN glitch filter, lock loss, retries, fault and relock
      for (int r = 0; r < 17; r++) begin
         bus.pll_lock   = tbl[r].lock;
         bus.relock_req = tbl[r].relock;
         for (int c = 0; c < tbl[r].n; c++) begin
            tick();
            check($sformatf("row%0d_cyc%0d", r, c), {2'b00, obs()}, {2'b00, tbl[r].exp});
         end
      end
      bus.relock_req = 1'b0;
`ifdef LOCK_LOSS_COUNT_EN
      check("loss_count_after_loss", bus.loss_count, 8'd1);
`endif

      // Unstable lock: one-cycle dropout in STABLE returns to WAIT_LOCK
      do_reset("t3_async_rst");
      bus.pll_lock = 1'b0;
      for (int i = 1; i <= 4; i++) tick();
      check("t3_wait_entry", {7'd0, bus.pll_rst}, 8'd0);
      bus.pll_lock = 1'b1;
      for (int i = 5; i <= 9; i++) tick();
      bus.pll_lock = 1'b0;
      tick();
      bus.pll_lock = 1'b1;
      for (int e = 11; e <= 22; e++) begin
         tick();
         check($sformatf("t3_edge%0d", e), {6'd0, bus.sys_rst_n, bus.locked},
               (e >= 21) ? 8'd3 : 8'd0);
      end

      // Async reset while in RUN, then a clean restart
      do_reset("t6_async_in_run");
`ifdef LOCK_LOSS_COUNT_EN
      check("t6_loss_count_cleared", bus.loss_count, 8'd0);
`endif
      bus.pll_lock = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check($sformatf("t6_restart_rst%0d", i), {2'b00, obs()}, 8'b0010_0000);
      end
      tick();
      check("t6_restart_wait", {2'b00, obs()}, 8'b0000_0000);

      // Priority: relock_req on the final-timeout cycle with retry_count=2
      do_reset("t5_async_rst");
      for (int i = 1; i <= 71; i++) tick();
      check("t5_last_wait", {2'b00, obs()}, 8'b0000_0010);
      bus.relock_req = 1'b1;
      tick();
      bus.relock_req = 1'b0;
      check("t5_relock_wins", {2'b00, obs()}, 8'b0010_0000);
      // relock_req inside RESET must not restart the pulse
      tick();
      bus.relock_req = 1'b1;
      tick();
      bus.relock_req = 1'b0;
      check("t5_reset_mid", {2'b00, obs()}, 8'b0010_0000);
      tick();
      check("t5_reset_last", {2'b00, obs()}, 8'b0010_0000);
      tick();
      check("t5_reset_len", {2'b00, obs()}, 8'b0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
